// File: rtl/reg_file_scoreboard_pkg.sv
// Shared types and sizes for the decode-stage register file and its busy scoreboard.
package reg_file_scoreboard_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned SEL_W    = 3;

    typedef logic [SEL_W-1:0]    reg_idx_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef data_t [NUM_REGS-1:0] rf_arr_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    // One-hot mask with only bit idx set.
    function automatic reg_mask_t idx_onehot(input reg_idx_t idx);
        return reg_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard_rf_read_port.sv
// One combinational read port: writeback bypass in front of an 8:1 bitwise AND-OR select.
module rf_read_port
    import reg_file_scoreboard_pkg::*;
(
    input  rf_arr_t  i_regs,
    input  reg_idx_t i_sel,
    input  logic     i_byp_en,
    input  logic     i_wr_en,
    input  reg_idx_t i_wr_sel,
    input  data_t    i_wr_data,
    output data_t    o_data
);

    reg_mask_t w_sel_oh;
    data_t     w_mux;
    logic      w_byp_hit;

    assign w_sel_oh = idx_onehot(i_sel);

    // Bitwise 8:1 mux: mask each entry with its select bit and OR together.
    always_comb begin
        w_mux = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_mux = w_mux | (i_regs[i] & {DATA_W{w_sel_oh[i]}});
        end
    end

    assign w_byp_hit = i_byp_en & i_wr_en & (i_wr_sel == i_sel);
    assign o_data    = w_byp_hit ? i_wr_data : w_mux;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural register file (8x16, 2R/1W) with a per-register busy scoreboard
// that stalls decode on RAW and WAW hazards.
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_idx_t  rd_sel1,
    input  logic      rd_use1,
    output data_t     rd_data1,
    input  reg_idx_t  rd_sel2,
    input  logic      rd_use2,
    output data_t     rd_data2,
    input  logic      wr_en,
    input  reg_idx_t  wr_sel,
    input  data_t     wr_data,
    input  logic      iss_en,
    input  reg_idx_t  iss_dst,
    input  logic      flush,
    output logic      stall,
    output reg_mask_t busy_vec
);

    rf_arr_t   r_regs;
    reg_mask_t r_busy;

    reg_mask_t w_wr_mask;
    reg_mask_t w_busy_eff;
    reg_mask_t w_busy_nxt;
    logic      w_iss_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else if (wr_en) begin
            r_regs[wr_sel] <= wr_data;
        end
    end

    // Bypass is gated by rst_n so reads stay zero while reset is held.
    rf_read_port u_rd1 (
        .i_regs    (r_regs),
        .i_sel     (rd_sel1),
        .i_byp_en  (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_sel  (wr_sel),
        .i_wr_data (wr_data),
        .o_data    (rd_data1)
    );

    rf_read_port u_rd2 (
        .i_regs    (r_regs),
        .i_sel     (rd_sel2),
        .i_byp_en  (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_sel  (wr_sel),
        .i_wr_data (wr_data),
        .o_data    (rd_data2)
    );

    // A register whose writeback lands this cycle is no longer a hazard.
    assign w_wr_mask  = wr_en ? idx_onehot(wr_sel) : '0;
    assign w_busy_eff = r_busy & ~w_wr_mask;

    assign stall = (rd_use1 & w_busy_eff[rd_sel1])
                 | (rd_use2 & w_busy_eff[rd_sel2])
                 | (iss_en  & w_busy_eff[iss_dst]);

    assign w_iss_acc = iss_en & ~stall & ~flush;

    // Flush beats everything; otherwise clear on writeback, then set on issue.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            w_busy_nxt = w_busy_nxt & ~w_wr_mask;
            if (w_iss_acc) begin
                w_busy_nxt = w_busy_nxt | idx_onehot(iss_dst);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: reset, bypass, RAW/WAW stalls, flush, async reset.
module tb_reg_file_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [2:0]  rd_sel1;
    logic        rd_use1;
    logic [15:0] rd_data1;
    logic [2:0]  rd_sel2;
    logic        rd_use2;
    logic [15:0] rd_data2;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        iss_en;
    logic [2:0]  iss_dst;
    logic        flush;
    logic        stall;
    logic [7:0]  busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    reg_file_scoreboard dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_sel1  (rd_sel1),
        .rd_use1  (rd_use1),
        .rd_data1 (rd_data1),
        .rd_sel2  (rd_sel2),
        .rd_use2  (rd_use2),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_dst  (iss_dst),
        .flush    (flush),
        .stall    (stall),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        rd_sel1 = 3'd0; rd_use1 = 1'b0;
        rd_sel2 = 3'd0; rd_use2 = 1'b0;
        wr_en = 1'b0; wr_sel = 3'd0; wr_data = 16'h0000;
        iss_en = 1'b0; iss_dst = 3'd0;
        flush = 1'b0;
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 8; i++) begin
            rd_sel1 = 3'(i);
            rd_sel2 = 3'(7 - i);
            #1;
            n_cmp++;
            if (rd_data1 !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_rd1 sel=%0d got=%h exp=0000", i, rd_data1);
            end
            n_cmp++;
            if (rd_data2 !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_rd2 sel=%0d got=%h exp=0000", 7 - i, rd_data2);
            end
        end
        n_cmp++;
        if (busy_vec !== 8'h00) begin
            n_err++;
            $display("FAIL reset_busy got=%h exp=00", busy_vec);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall got=%b exp=0", stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        idle_inputs();
        wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hBEEF;
        rd_sel1 = 3'd3; rd_sel2 = 3'd4;
        #1;
        n_cmp++;
        if (rd_data1 !== 16'hBEEF) begin
            n_err++;
            $display("FAIL bypass_same_cycle got=%h exp=beef", rd_data1);
        end
        n_cmp++;
        if (rd_data2 !== 16'h0000) begin
            n_err++;
            $display("FAIL bypass_other_sel got=%h exp=0000", rd_data2);
        end
        step();
        wr_en = 1'b0;
        rd_sel2 = 3'd3;
        #1;
        n_cmp++;
        if (rd_data1 !== 16'hBEEF) begin
            n_err++;
            $display("FAIL bypass_storage_rd1 got=%h exp=beef", rd_data1);
        end
        n_cmp++;
        if (rd_data2 !== 16'hBEEF) begin
            n_err++;
            $display("FAIL bypass_storage_rd2 got=%h exp=beef", rd_data2);
        end
    endtask

    task automatic test_raw();
        idle_inputs();
        iss_en = 1'b1; iss_dst = 3'd5;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL raw_issue_stall got=%b exp=0", stall);
        end
        step();
        iss_en = 1'b0;
        n_cmp++;
        if (busy_vec !== 8'h20) begin
            n_err++;
            $display("FAIL raw_busy_set got=%h exp=20", busy_vec);
        end
        rd_sel2 = 3'd5; rd_use2 = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL raw_stall_use got=%b exp=1", stall);
        end
        rd_use2 = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL raw_stall_nouse got=%b exp=0", stall);
        end
        rd_sel1 = 3'd5; rd_use1 = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL raw_stall_port1 got=%b exp=1", stall);
        end
        rd_use1 = 1'b0;
        rd_use2 = 1'b1;
        wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'h1234;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL raw_wb_stall got=%b exp=0", stall);
        end
        n_cmp++;
        if (rd_data2 !== 16'h1234) begin
            n_err++;
            $display("FAIL raw_wb_bypass got=%h exp=1234", rd_data2);
        end
        step();
        wr_en = 1'b0;
        #1;
        n_cmp++;
        if (busy_vec !== 8'h00) begin
            n_err++;
            $display("FAIL raw_busy_clr got=%h exp=00", busy_vec);
        end
        n_cmp++;
        if (rd_data2 !== 16'h1234) begin
            n_err++;
            $display("FAIL raw_storage got=%h exp=1234", rd_data2);
        end
    endtask

    task automatic test_waw();
        idle_inputs();
        iss_en = 1'b1; iss_dst = 3'd2;
        step();
        n_cmp++;
        if (busy_vec !== 8'h04) begin
            n_err++;
            $display("FAIL waw_busy_set got=%h exp=04", busy_vec);
        end
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL waw_stall got=%b exp=1", stall);
        end
        step();
        n_cmp++;
        if (busy_vec !== 8'h04) begin
            n_err++;
            $display("FAIL waw_busy_hold got=%h exp=04", busy_vec);
        end
        wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'h0202;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL waw_wb_stall got=%b exp=0", stall);
        end
        step();
        iss_en = 1'b0;
        n_cmp++;
        if (busy_vec !== 8'h04) begin
            n_err++;
            $display("FAIL waw_set_wins got=%h exp=04", busy_vec);
        end
        wr_data = 16'h2222;
        step();
        wr_en = 1'b0;
        n_cmp++;
        if (busy_vec !== 8'h00) begin
            n_err++;
            $display("FAIL waw_final_clr got=%h exp=00", busy_vec);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        iss_en = 1'b1;
        iss_dst = 3'd1; step();
        iss_dst = 3'd3; step();
        iss_dst = 3'd7; step();
        n_cmp++;
        if (busy_vec !== 8'h8A) begin
            n_err++;
            $display("FAIL flush_pre_busy got=%h exp=8a", busy_vec);
        end
        iss_dst = 3'd0; flush = 1'b1;
        wr_en = 1'b1; wr_sel = 3'd6; wr_data = 16'h6666;
        step();
        idle_inputs();
        n_cmp++;
        if (busy_vec !== 8'h00) begin
            n_err++;
            $display("FAIL flush_busy got=%h exp=00", busy_vec);
        end
        rd_sel1 = 3'd3; rd_sel2 = 3'd6;
        #1;
        n_cmp++;
        if (rd_data1 !== 16'hBEEF) begin
            n_err++;
            $display("FAIL flush_keep_data got=%h exp=beef", rd_data1);
        end
        n_cmp++;
        if (rd_data2 !== 16'h6666) begin
            n_err++;
            $display("FAIL flush_write_data got=%h exp=6666", rd_data2);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        iss_en = 1'b1; iss_dst = 3'd0;
        step();
        wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'hAAAA;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_reissue_stall got=%b exp=0", stall);
        end
        step();
        iss_en = 1'b0;
        wr_data = 16'hA0A0;
        n_cmp++;
        if (busy_vec !== 8'h01) begin
            n_err++;
            $display("FAIL b2b_busy_reissue got=%h exp=01", busy_vec);
        end
        step();
        wr_sel = 3'd4; wr_data = 16'h4444;
        n_cmp++;
        if (busy_vec !== 8'h00) begin
            n_err++;
            $display("FAIL b2b_busy_done got=%h exp=00", busy_vec);
        end
        step();
        wr_en = 1'b0;
        rd_sel1 = 3'd0; rd_sel2 = 3'd4;
        #1;
        n_cmp++;
        if (busy_vec !== 8'h00) begin
            n_err++;
            $display("FAIL b2b_nonbusy_write got=%h exp=00", busy_vec);
        end
        n_cmp++;
        if (rd_data1 !== 16'hA0A0) begin
            n_err++;
            $display("FAIL b2b_rd_r0 got=%h exp=a0a0", rd_data1);
        end
        n_cmp++;
        if (rd_data2 !== 16'h4444) begin
            n_err++;
            $display("FAIL b2b_rd_r4 got=%h exp=4444", rd_data2);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 16'h5555;
        iss_en = 1'b1; iss_dst = 3'd7;
        step();
        idle_inputs();
        rd_sel1 = 3'd7; rd_use1 = 1'b1;
        #1;
        n_cmp++;
        if (busy_vec !== 8'h80 || rd_data1 !== 16'h5555 || stall !== 1'b1) begin
            n_err++;
            $display("FAIL arst_pre busy=%h rd1=%h stall=%b exp=80/5555/1", busy_vec, rd_data1, stall);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rd_data1 !== 16'h0000) begin
            n_err++;
            $display("FAIL arst_data got=%h exp=0000", rd_data1);
        end
        n_cmp++;
        if (busy_vec !== 8'h00) begin
            n_err++;
            $display("FAIL arst_busy got=%h exp=00", busy_vec);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL arst_stall got=%b exp=0", stall);
        end
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 16'h9999;
        #1;
        n_cmp++;
        if (rd_data1 !== 16'h0000) begin
            n_err++;
            $display("FAIL arst_no_bypass got=%h exp=0000", rd_data1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (rd_data1 !== 16'h9999) begin
            n_err++;
            $display("FAIL arst_bypass_back got=%h exp=9999", rd_data1);
        end
        step();
        wr_en = 1'b0;
        #1;
        n_cmp++;
        if (rd_data1 !== 16'h9999) begin
            n_err++;
            $display("FAIL arst_first_edge got=%h exp=9999", rd_data1);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        test_reset();
        test_bypass();
        test_raw();
        test_waw();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
